cons_heap: RTL and testbench
============================

// Module: cons_heap
// PURPOSE
//   Responder side of the core's heap memory port: serves single-word read requests
//   (req/addr_in -> data_ready/data_out) after a fixed latency, and services bump
//   allocation writes (write_enable/write_data -> write_result_addr).
//   Sits between the evaluator FSM and the on-chip block RAM holding the program
//   image and the cons cells allocated at run time.
// PARAMETERS
//   ADDR_W        12          address width; heap depth = 2**ADDR_W words
//   DATA_W        16          word width (tagged object: [15] spare, [14:12] tag, [11:0] ptr)
//   READ_LATENCY  2           cycles from req cycle to data_ready cycle; legal range 1..15
//   HEAP_BASE     12'h010     first allocatable address; words below are program image
//   INIT_FILE     ""          $readmemh image loaded at elaboration; "" = all-zero RAM
// PORTS
//   clk               in   1       rising-edge clock
//   rst_n             in   1       asynchronous active-low reset
//   req               in   1       single-cycle read request pulse
//   addr_in           in   ADDR_W  read address, sampled in the req cycle
//   data_ready        out  1       one-cycle pulse: data_out valid
//   data_out          out  DATA_W  read word; held until the next accepted read completes
//   busy              out  1       read in flight; req ignored while high
//   write_enable      in   1       allocate one word this cycle
//   write_data        in   DATA_W  word to store at the free pointer
//   write_result_addr out  ADDR_W  address the last accepted write went to
//   heap_full         out  1       no free word left; further writes dropped
//   bounds_err        out  1       sticky; see CONFIGURATION
// BEHAVIOUR
//   Reset (async assert, sync release): data_ready=0, data_out=0, busy=0,
//     write_result_addr=0, heap_full=0, bounds_err=0, free_ptr=HEAP_BASE, FSM=IDLE.
//     RAM contents NOT cleared by reset; INIT_FILE is loaded at elaboration only.
//   free_ptr is ADDR_W+1 bits; heap_full = (free_ptr == 2**ADDR_W), combinational.
//   Read FSM: IDLE -> WAIT -> RESPOND -> IDLE.
//     IDLE: req=1 -> latch addr_in, load cnt=READ_LATENCY-1, busy=1;
//           goto RESPOND if READ_LATENCY==1, else WAIT.
//     WAIT: cnt decrements; at cnt==1 goto RESPOND.
//     RESPOND: array read registered into data_out, data_ready=1 for exactly this
//       cycle, busy=0 at the next edge; -> IDLE.
//     req in the cycle the FSM is in IDLE (incl. the cycle after RESPOND) is accepted;
//       in WAIT/RESPOND it is dropped silently.
//   Latency: req in cycle N -> data_ready high in cycle N+READ_LATENCY.
//   data_out is stable from the data_ready cycle until the next data_ready; the
//     consumer may sample it one cycle late.
//   Write: write_enable && !heap_full -> mem[free_ptr] <= write_data,
//     write_result_addr <= free_ptr, free_ptr++ (all at the same edge).
//     write_enable && heap_full -> no store, write_result_addr and free_ptr unchanged.
//   Collision: the array is read in the RESPOND cycle; a write in an earlier cycle of the
//     same read is visible; a write to the same address in the RESPOND cycle is not
//     (read-before-write).
//   Read and write in the same cycle are independent; both are serviced.
//   Reset mid-read: FSM returns to IDLE, no data_ready is produced for the aborted req.
// CONFIGURATION
//   HEAP_BOUNDS_CHECK_EN defined: an accepted req with addr_in >= free_ptr[ADDR_W-1:0]
//     and addr_in >= HEAP_BASE (unallocated word) still completes normally, but sets
//     bounds_err (sticky until reset). A write attempted while heap_full also sets it.
//   Not defined: bounds_err tied to 0; no comparators are synthesised.
// TESTING
//   1. INIT_FILE with mem[4]=16'h1004; req addr 4 in cycle 0, READ_LATENCY=2
//      -> data_ready=1 only in cycle 2, data_out=16'h1004 held through cycle 5.
//   2. Reset, 3 writes (16'hA,16'hB,16'hC) -> write_result_addr 0x010,0x011,0x012;
//      read 0x011 -> 16'h000B.
//   3. req at cycle 0 and again at cycle 1 (busy) -> one data_ready only; req in the
//      cycle after data_ready -> accepted, second data_ready 2 cycles later.
//   4. Fill heap to 2**ADDR_W words -> heap_full=1; extra write leaves write_result_addr
//      =12'hFFF; with HEAP_BOUNDS_CHECK_EN bounds_err=1.
//   5. Write 16'h55AA to addr X in RESPOND cycle of a read of X -> old data returned;
//      re-read -> 16'h55AA.
//   6. Assert rst_n=0 during WAIT -> no data_ready, busy=0, free_ptr=HEAP_BASE.

Source files
------------

// File: rtl/cons_heap.sv
// cons_heap: responder side of the core's heap memory port.
//   - Fixed-latency single-word reads (req/addr_in -> data_ready/data_out),
//     sequenced by a small IDLE/WAIT/RESPOND FSM.
//   - Bump allocation writes at free_ptr (write_enable/write_data -> write_result_addr).
// Optional feature macro: HEAP_BOUNDS_CHECK_EN
//   defined   : bounds_err flags reads of unallocated words and writes into a full heap
//   undefined : bounds_err tied low, no comparators
module cons_heap #(
  parameter int                ADDR_W       = 12,
  parameter int                DATA_W       = 16,
  parameter int                READ_LATENCY = 2,
  parameter logic [ADDR_W-1:0] HEAP_BASE    = 12'h010,
  parameter                    INIT_FILE    = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              data_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  input  logic              write_enable,
  input  logic [DATA_W-1:0] write_data,
  output logic [ADDR_W-1:0] write_result_addr,
  output logic              heap_full,
  output logic              bounds_err
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   FULL_PTR = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [3:0]        CNT_LOAD = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     free_ptr;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic                wr_ok;
  logic                load_out;
  logic [ADDR_W-1:0]   rd_addr;
  logic                wr_hit;

  assign heap_full = (free_ptr == FULL_PTR);
  assign wr_ok     = write_enable && !heap_full;
  assign accept    = (state == IDLE) && req;

  // With READ_LATENCY==1 the word is fetched straight off addr_in in the req cycle.
  assign rd_addr   = (state == IDLE) ? addr_in : addr_q;

  // The output register is loaded on the edge that enters RESPOND so data_out is
  // already valid while data_ready is high. A write committing on that same edge
  // belongs to an earlier cycle of the read and must be seen, hence the bypass;
  // a write in the RESPOND cycle itself lands after the load (read-before-write).
  assign load_out  = (state_nxt == RESPOND);
  assign wr_hit    = wr_ok && (free_ptr[ADDR_W-1:0] == rd_addr);

  // Read FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Read FSM: next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = (READ_LATENCY == 1) ? RESPOND : WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = RESPOND;
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read FSM: outputs decoded from the current state
  always_comb begin
    data_ready = 1'b0;
    busy       = 1'b0;
    case (state)
      WAIT:    busy = 1'b1;
      RESPOND: begin
        busy       = 1'b1;
        data_ready = 1'b1;
      end
      default: ;
    endcase
  end

  // Latency counter and captured read address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      addr_q <= '0;
    end else if (accept) begin
      cnt    <= CNT_LOAD;
      addr_q <= addr_in;
    end else if (state == WAIT) begin
      cnt    <= cnt - 4'd1;
    end
  end

  // Read data register: held until the next completed read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        data_out <= '0;
    else if (load_out) data_out <= wr_hit ? write_data : mem[rd_addr];
  end

  // Heap array write port
  always_ff @(posedge clk) begin
    if (wr_ok) mem[free_ptr[ADDR_W-1:0]] <= write_data;
  end

  // Bump allocator: free pointer and last-written address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_ptr          <= {1'b0, HEAP_BASE};
      write_result_addr <= '0;
    end else if (wr_ok) begin
      free_ptr          <= free_ptr + (ADDR_W+1)'(1);
      write_result_addr <= free_ptr[ADDR_W-1:0];
    end
  end

`ifdef HEAP_BOUNDS_CHECK_EN
  logic rd_oob;
  // A read above the allocation frontier (but inside the heap region) is unallocated.
  assign rd_oob = accept && (addr_in >= free_ptr[ADDR_W-1:0]) && (addr_in >= HEAP_BASE);

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  bounds_err <= 1'b0;
    else if (rd_oob || (write_enable && heap_full)) bounds_err <= 1'b1;
  end
`else
  assign bounds_err = 1'b0;
`endif

endmodule

// File: tb/tb_cons_heap.sv
// tb_cons_heap: scoreboard bench for cons_heap (ADDR_W=12, READ_LATENCY=2).
// Expected read data and due cycle are queued when a req is driven; a negedge
// monitor pops and compares on every data_ready.
module tb_cons_heap;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int LAT    = 2;
`ifdef HEAP_BOUNDS_CHECK_EN
  localparam logic BCHK = 1'b1;
`else
  localparam logic BCHK = 1'b0;
`endif

  typedef struct {
    logic [DATA_W-1:0] d;
    int                due;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req;
  logic [ADDR_W-1:0] addr_in;
  logic              data_ready;
  logic [DATA_W-1:0] data_out;
  logic              busy;
  logic              write_enable;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] write_result_addr;
  logic              heap_full;
  logic              bounds_err;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   rdy_cnt = 0;
  exp_t exp_q[$];

  cons_heap #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(LAT),
    .HEAP_BASE(12'h010), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .addr_in(addr_in),
    .data_ready(data_ready), .data_out(data_out), .busy(busy),
    .write_enable(write_enable), .write_data(write_data),
    .write_result_addr(write_result_addr),
    .heap_full(heap_full), .bounds_err(bounds_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard side: every data_ready must match the oldest queued read
  always @(negedge clk) begin
    if (rst_n && data_ready) begin
      rdy_cnt++;
      if (exp_q.size() == 0) chk("spurious_rdy", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rd_data", 32'(data_out), 32'(e.d));
        chk("rd_lat", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 1'b0; addr_in = '0;
    write_enable = 1'b0; write_data = '0;
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wr(input logic [DATA_W-1:0] d);
    write_enable = 1'b1; write_data = d;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] expd);
    exp_t e;
    e.d = expd; e.due = cyc + LAT;
    exp_q.push_back(e);
    req = 1'b1; addr_in = a;
    tick();
    req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int r0;
    do_reset();
    // Reset state
    chk("rst_rdy",  32'(data_ready), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wra",  32'(write_result_addr), 32'd0);
    chk("rst_full", 32'(heap_full), 32'd0);
    chk("rst_berr", 32'(bounds_err), 32'd0);

    // Allocation sequence and readback, with hold of data_out
    wr(16'h000A); chk("wra0", 32'(write_result_addr), 32'h010);
    wr(16'h000B); chk("wra1", 32'(write_result_addr), 32'h011);
    wr(16'h000C); chk("wra2", 32'(write_result_addr), 32'h012);
    rd(12'h011, 16'h000B);
    chk("busy_wait", 32'(busy), 32'd1);
    drain();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold", 32'(data_out), 32'h000B);
    end
    chk("berr_inrange", 32'(bounds_err), 32'd0);

    // Req while busy dropped; req right after data_ready accepted
    r0 = rdy_cnt;
    rd(12'h010, 16'h000A);      // cycle N, now N+1
    req = 1'b1; addr_in = 12'h012;
    tick();                      // dropped, now N+2 (RESPOND)
    req = 1'b0;
    tick();                      // N+3
    rd(12'h012, 16'h000C);
    drain();
    repeat (3) tick();
    chk("rdy_count", 32'(rdy_cnt - r0), 32'd2);

    // Collision: RAM survives reset, free_ptr back at 0x010 which holds 0x000A
    do_reset();
    rd(12'h010, 16'h000A);       // now WAIT
    tick();                      // now RESPOND
    wr(16'h55AA);
    chk("wra_coll", 32'(write_result_addr), 32'h010);
    drain();
    rd(12'h010, 16'h55AA);
    drain();
    // Write in the cycle before RESPOND must be visible
    rd(12'h011, 16'h1234);       // now WAIT, free_ptr=0x011
    wr(16'h1234);
    drain();

    // Reset during WAIT aborts the read
    r0 = rdy_cnt;
    req = 1'b1; addr_in = 12'h010;
    tick();
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("abort_rdy", 32'(rdy_cnt - r0), 32'd0);
    chk("abort_berr", 32'(bounds_err), 32'd0);
    wr(16'h7777);
    chk("abort_ptr", 32'(write_result_addr), 32'h010);

    // Read of unallocated word 0x011 (free_ptr=0x011): completes, flags bounds_err
    rd(12'h011, 16'h1234);
    drain();
    chk("berr_oob", 32'(bounds_err), 32'(BCHK));

    // Fill the heap
    do_reset();
    chk("berr_clr", 32'(bounds_err), 32'd0);
    write_enable = 1'b1;
    for (int i = 0; i < (1 << ADDR_W) - 16; i++) begin
      write_data = 16'(i);
      tick();
    end
    write_enable = 1'b0;
    chk("full", 32'(heap_full), 32'd1);
    chk("full_wra", 32'(write_result_addr), 32'hFFF);
    chk("full_berr0", 32'(bounds_err), 32'd0);
    wr(16'hDEAD);
    chk("full_drop_wra", 32'(write_result_addr), 32'hFFF);
    chk("full_still", 32'(heap_full), 32'd1);
    chk("full_berr", 32'(bounds_err), 32'(BCHK));
    rd(12'hFFF, 16'h0FEF);
    drain();
    rd(12'h010, 16'h0000);
    drain();

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
